spi_master: RTL and testbench

//  SPI master that drives the SPI slave + RAM subsystem from a parallel command port.

---
 rtl/spi_master.sv | 172 +++++++++++++++++
 tb/tb_spi_master.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// SPI master: serialises 10-bit command words onto MOSI under SS_n framing,
// one bit per system clock, and for read-data commands captures the 8-bit
// reply from MISO after a fixed turnaround.
//
// Handshake: a command is accepted on the rising edge where cmd_valid and
// cmd_ready are both high; cmd_ready is high only while the master is idle,
// so cmd_valid presented at any other time is simply not taken.
module spi_master #(
    parameter int unsigned RD_LAT = 2,   // turnaround cycles before the first MISO sample (1..15)
    parameter int unsigned GAP    = 1    // SS_n-high cycles after every frame (1..15)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    input  logic [9:0] cmd_data,
    output logic       cmd_ready,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       busy,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SEL       = 3'd1,
        S_SHIFT_OUT = 3'd2,
        S_WAIT      = 3'd3,
        S_SHIFT_IN  = 3'd4,
        S_GAP       = 3'd5
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [9:0] sh_q, sh_d;           // command latched at accept
    logic [7:0] rx_q, rx_d;           // partial reply, never visible outside
    logic [7:0] rsp_data_q, rsp_data_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic       ss_n_q, ss_n_d;
    logic       mosi_q, mosi_d;
    logic       busy_q, busy_d;
    logic       ready_q, ready_d;

    // Next-state, counters and capture; outputs decoded from the next state
    // so that every port comes straight from a flop.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sh_d        = sh_q;
        rx_d        = rx_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = 1'b0;
        ss_n_d      = 1'b1;
        mosi_d      = 1'b0;
        busy_d      = 1'b1;
        ready_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    sh_d    = cmd_data;
                    state_d = S_SEL;
                end
            end
            S_SEL: begin
                state_d = S_SHIFT_OUT;
                cnt_d   = 4'd9;
            end
            S_SHIFT_OUT: begin
                if (cnt_q == 4'd0) begin
                    // Decision uses the latched opcode, never the live input.
                    if (sh_q[9:8] == 2'b11) begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(RD_LAT - 1);
                    end else begin
                        state_d = S_GAP;
                        cnt_d   = 4'(GAP - 1);
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_SHIFT_IN;
                    cnt_d   = 4'd7;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_SHIFT_IN: begin
                rx_d = {rx_q[6:0], MISO};
                if (cnt_q == 4'd0) begin
                    rsp_data_d  = {rx_q[6:0], MISO};
                    rsp_valid_d = 1'b1;
                    state_d     = S_GAP;
                    cnt_d       = 4'(GAP - 1);
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_GAP: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        case (state_d)
            S_IDLE: begin
                busy_d  = 1'b0;
                ready_d = 1'b1;
            end
            S_SEL: begin
                ss_n_d = 1'b0;
                mosi_d = sh_d[9];
            end
            S_SHIFT_OUT: begin
                ss_n_d = 1'b0;
                mosi_d = sh_d[cnt_d];
            end
            S_WAIT, S_SHIFT_IN: begin
                ss_n_d = 1'b0;
            end
            default: begin
            end
        endcase
    end

    // State and output registers, cleared asynchronously; a cut frame is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            sh_q        <= 10'd0;
            rx_q        <= 8'd0;
            rsp_data_q  <= 8'd0;
            rsp_valid_q <= 1'b0;
            ss_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sh_q        <= sh_d;
            rx_q        <= rx_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
            ss_n_q      <= ss_n_d;
            mosi_q      <= mosi_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
        end
    end

    assign cmd_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = busy_q;
    assign SS_n      = ss_n_q;
    assign MOSI      = mosi_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: a behavioural SPI slave + RAM sits on the serial
// pins, a monitor turns each SS_n-low window into a frame record, and the
// records are compared with a table of known vectors, hand-written corner
// sequences and a high-level reference model under random commands.
module tb_spi_master;

    localparam int RD_LAT = 2;
    localparam int GAP    = 1;
    localparam int WR_LEN = 11;
    localparam int RD_LEN = 11 + RD_LAT + 8;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic [9:0] cmd_data;
    logic       cmd_ready;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       busy;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;
    logic [2:0] dbg_state;

    spi_master #(.RD_LAT(RD_LAT), .GAP(GAP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_data  (cmd_data),
        .cmd_ready (cmd_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .SS_n      (SS_n),
        .MOSI      (MOSI),
        .MISO      (MISO),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- counters ----------------
    int n_vec  = 0;
    int n_miss = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- slave + RAM model and frame monitor ----------------
    logic [7:0]  s_mem [256];
    logic [7:0]  s_waddr = 8'h00;
    logic [7:0]  s_raddr = 8'h00;
    logic [7:0]  s_reply = 8'h00;
    bit          s_rd    = 1'b0;
    int          low_cnt = 0;
    int          high_cnt = 100;
    int          high_before = 0;
    bit          prev_ss = 1'b1;
    logic [10:0] frame_bits = 11'd0;
    bit          tail_nz = 1'b0;
    int          rsp_pulses = 0;

    logic [31:0] obs_len_q  [$];
    logic [10:0] obs_bits_q [$];
    logic [0:0]  obs_tail_q [$];
    logic [0:0]  obs_rv_q   [$];
    logic [7:0]  obs_rd_q   [$];
    logic [31:0] obs_gap_q  [$];

    initial begin
        for (int i = 0; i < 256; i++) s_mem[i] = 8'h00;
    end

    always @(negedge clk) begin
        if (rsp_valid === 1'b1) rsp_pulses++;
        if (!rst_n) begin
            low_cnt = 0;
            prev_ss = 1'b1;
            s_rd    = 1'b0;
            MISO    = 1'b0;
        end else if (SS_n === 1'b0) begin
            if (prev_ss) begin
                high_before = high_cnt;
                frame_bits  = 11'd0;
                tail_nz     = 1'b0;
                s_rd        = 1'b0;
            end
            low_cnt++;
            if (low_cnt <= 11) frame_bits = {frame_bits[9:0], MOSI};
            else if (MOSI !== 1'b0) tail_nz = 1'b1;
            if (low_cnt == 11) begin
                case (frame_bits[9:8])
                    2'b00: s_waddr = frame_bits[7:0];
                    2'b01: s_mem[s_waddr] = frame_bits[7:0];
                    2'b10: s_raddr = frame_bits[7:0];
                    default: begin
                        s_reply = s_mem[s_raddr];
                        s_rd    = 1'b1;
                    end
                endcase
            end
            // Reply bits are presented for the sampling edges of the capture
            // window; everywhere else MISO carries noise the master must ignore.
            if (s_rd && low_cnt >= 12 + RD_LAT && low_cnt <= 19 + RD_LAT)
                MISO = s_reply[7 - (low_cnt - 12 - RD_LAT)];
            else
                MISO = 1'($urandom_range(0, 1));
            prev_ss = 1'b0;
        end else begin
            if (!prev_ss) begin
                obs_len_q.push_back(low_cnt);
                obs_bits_q.push_back(frame_bits);
                obs_tail_q.push_back(tail_nz);
                obs_rv_q.push_back(rsp_valid);
                obs_rd_q.push_back(rsp_data);
                obs_gap_q.push_back(high_before);
                low_cnt  = 0;
                high_cnt = 0;
            end
            high_cnt++;
            MISO    = 1'($urandom_range(0, 1));
            prev_ss = 1'b1;
        end
    end

    // ---------------- reference model ----------------
    logic [7:0] ref_mem [256];
    logic [7:0] ref_waddr = 8'h00;
    logic [7:0] ref_raddr = 8'h00;
    int         exp_pulses = 0;

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    end

    // What one command should look like on the wire, and what it returns.
    task automatic model_cmd(input logic [9:0] c, output int len, output logic [10:0] bits,
                             output bit is_rd, output logic [7:0] rsp);
        bits  = {c[9], c};
        is_rd = (c[9:8] == 2'b11);
        len   = is_rd ? RD_LEN : WR_LEN;
        rsp   = 8'h00;
        case (c[9:8])
            2'b00: ref_waddr = c[7:0];
            2'b01: ref_mem[ref_waddr] = c[7:0];
            2'b10: ref_raddr = c[7:0];
            default: begin
                rsp = ref_mem[ref_raddr];
                exp_pulses++;
            end
        endcase
    endtask

    // ---------------- scoreboard ----------------
    logic [31:0] exp_len_q  [$];
    logic [10:0] exp_bits_q [$];
    logic [0:0]  exp_rd_q   [$];
    logic [7:0]  exp_q      [$];
    logic [31:0] last_gap;

    task automatic check_frame(input string name, input int len, input logic [10:0] bits,
                               input bit is_rd, input logic [7:0] rsp);
        cmp({name, "_present"}, 32'(obs_len_q.size() != 0), 1);
        if (obs_len_q.size() == 0) return;
        cmp({name, "_ss_low_len"}, obs_len_q.pop_front(), len);
        cmp({name, "_mosi_bits"}, 32'(obs_bits_q.pop_front()), 32'(bits));
        cmp({name, "_mosi_tail"}, 32'(obs_tail_q.pop_front()), 0);
        cmp({name, "_rsp_valid_gap"}, 32'(obs_rv_q.pop_front()), 32'(is_rd));
        if (is_rd) cmp({name, "_rsp_data"}, 32'(obs_rd_q.pop_front()), 32'(rsp));
        else void'(obs_rd_q.pop_front());
        last_gap = obs_gap_q.pop_front();
    endtask

    task automatic drain_expected(input string name);
        while (exp_len_q.size() != 0)
            check_frame(name, exp_len_q.pop_front(), exp_bits_q.pop_front(),
                        exp_rd_q.pop_front(), exp_q.pop_front());
    endtask

    // ---------------- driver tasks ----------------
    int accept_cyc;

    task automatic send_cmd(input logic [9:0] c, input bit hold);
        int n = 0;
        cmd_data  = c;
        cmd_valid = 1'b1;
        @(negedge clk);
        while (cmd_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (cmd_ready !== 1'b1) cmp("accept_timeout", 32'(cmd_ready), 1);
        @(posedge clk);
        #1;
        accept_cyc = cyc;
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!(busy === 1'b0 && cmd_ready === 1'b1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy !== 1'b0) cmp("idle_timeout", 32'(busy), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic send_modelled(input logic [9:0] c, input bit hold);
        int          len;
        logic [10:0] bits;
        bit          is_rd;
        logic [7:0]  rsp;
        send_cmd(c, hold);
        model_cmd(c, len, bits, is_rd, rsp);
        exp_len_q.push_back(len);
        exp_bits_q.push_back(bits);
        exp_rd_q.push_back(is_rd);
        exp_q.push_back(rsp);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [9:0] cmd;
        int         exp_len;
        logic [7:0] exp_rsp;
        bit         is_rd;
    } vec_t;

    vec_t tbl [12];

    initial begin
        int          len;
        logic [10:0] bits;
        bit          is_rd;
        logic [7:0]  rsp;
        bit          ready_low_all;
        int          a1;
        logic [9:0]  c;

        // wr_addr A5 / wr_data F0 / rd_addr A5 / rd_data -> F0
        tbl[0]  = '{10'b00_1010_0101, WR_LEN, 8'h00, 1'b0};
        tbl[1]  = '{10'b01_1111_0000, WR_LEN, 8'h00, 1'b0};
        tbl[2]  = '{10'b10_1010_0101, WR_LEN, 8'h00, 1'b0};
        tbl[3]  = '{10'b11_0000_0000, RD_LEN, 8'hF0, 1'b1};
        // end-to-end: wr_addr 10 / wr_data 5A / rd_addr 10 / rd_data -> 5A
        tbl[4]  = '{10'b00_0001_0000, WR_LEN, 8'h00, 1'b0};
        tbl[5]  = '{10'b01_0101_1010, WR_LEN, 8'h00, 1'b0};
        tbl[6]  = '{10'b10_0001_0000, WR_LEN, 8'h00, 1'b0};
        tbl[7]  = '{10'b11_0000_0000, RD_LEN, 8'h5A, 1'b1};
        // slave answering C3
        tbl[8]  = '{10'b00_0011_0011, WR_LEN, 8'h00, 1'b0};
        tbl[9]  = '{10'b01_1100_0011, WR_LEN, 8'h00, 1'b0};
        tbl[10] = '{10'b10_0011_0011, WR_LEN, 8'h00, 1'b0};
        tbl[11] = '{10'b11_1111_1111, RD_LEN, 8'hC3, 1'b1};

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_data  = 10'd0;
        MISO      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        cmp("rst_ss_n", 32'(SS_n), 1);
        cmp("rst_mosi", 32'(MOSI), 0);
        cmp("rst_cmd_ready", 32'(cmd_ready), 1);
        cmp("rst_busy", 32'(busy), 0);
        cmp("rst_rsp_valid", 32'(rsp_valid), 0);
        cmp("rst_rsp_data", 32'(rsp_data), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table vectors: each frame run to completion and checked against constants.
        for (int i = 0; i < 12; i++) begin
            send_cmd(tbl[i].cmd, 1'b0);
            model_cmd(tbl[i].cmd, len, bits, is_rd, rsp);
            wait_idle();
            check_frame($sformatf("tbl%0d", i), tbl[i].exp_len, {tbl[i].cmd[9], tbl[i].cmd},
                        tbl[i].is_rd, tbl[i].exp_rsp);
        end
        cmp("tbl_rsp_pulses", rsp_pulses, exp_pulses);

        // Back-to-back: the second word is already waiting when the first frame ends.
        // Spacing is SS_n-low + GAP + 1; between frames SS_n is high for the GAP
        // cycles plus the idle cycle in which the next word is accepted.
        send_modelled(10'b01_1111_0000, 1'b1);
        a1 = accept_cyc;
        send_modelled(10'b10_1010_0101, 1'b0);
        cmp("b2b_accept_spacing", accept_cyc - a1, WR_LEN + GAP + 1);
        wait_idle();
        drain_expected("b2b");
        cmp("b2b_ss_high_between", last_gap, GAP + 1);

        // Busy rejection: a different word held valid for the whole frame.
        send_modelled(10'b00_0110_1001, 1'b1);
        cmd_data      = 10'b01_1110_0111;
        ready_low_all = 1'b1;
        for (int k = 0; k < WR_LEN + GAP; k++) begin
            @(negedge clk);
            if (cmd_ready !== 1'b0 || busy !== 1'b1) ready_low_all = 1'b0;
        end
        cmd_valid = 1'b0;
        cmp("busy_ready_low_throughout", 32'(ready_low_all), 1);
        wait_idle();
        repeat (5) @(posedge clk);
        #1;
        drain_expected("busy");
        cmp("busy_single_frame", obs_len_q.size(), 0);

        // Reset mid-frame: cut a read-data frame during SHIFT_OUT.
        send_cmd(10'b11_0000_0000, 1'b0);
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        cmp("midrst_ss_n", 32'(SS_n), 1);
        cmp("midrst_busy", 32'(busy), 0);
        cmp("midrst_cmd_ready", 32'(cmd_ready), 1);
        cmp("midrst_mosi", 32'(MOSI), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        cmp("midrst_no_rsp", rsp_pulses, exp_pulses);
        cmp("midrst_no_frame", obs_len_q.size(), 0);
        send_modelled(10'b11_0000_0000, 1'b0);
        wait_idle();
        drain_expected("after_rst");

        // Random commands against the reference model.
        for (int i = 0; i < 40; i++) begin
            c = 10'($urandom_range(0, 1023));
            if ($urandom_range(0, 3) == 0) c[7:0] = 8'(c[7:4]);   // reuse a few addresses
            send_modelled(c, 1'b0);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        wait_idle();
        drain_expected("rnd");
        cmp("rnd_rsp_pulses", rsp_pulses, exp_pulses);
        cmp("rnd_no_extra_frames", obs_len_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
